// File: rtl/reg_display_scanner.sv
// rtl/reg_display_scanner.sv - debounced register-index stepper and 8-digit hex scanner
// Optional build macro: DISPLAY_ZERO_BLANK_EN (leading-zero blanking on digits 1..7).
module reg_display_scanner #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic [31:0] displayData,
  output logic [4:0]  displaySelect,
  output logic [4:0]  led_sel,
  output logic [6:0]  seg,
  output logic [7:0]  an
);

  localparam int TICK = CLK_HZ / SCAN_HZ;
  localparam int TW   = (TICK > 2) ? $clog2(TICK) : 1;
  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

  // bit 0 = next, bit 1 = prev
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    pulse;
  logic [DW-1:0] deb_cnt [2];

  assign raw = {btn_prev, btn_next};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      pulse <= '0;
      for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        pulse[b] <= 1'b0;
        if (sync2[b] != deb[b]) begin
          if (deb_cnt[b] == DEB_LAST) begin
            deb[b]     <= sync2[b];
            deb_cnt[b] <= '0;
            pulse[b]   <= sync2[b];
          end else begin
            deb_cnt[b] <= deb_cnt[b] + 1'b1;
          end
        end else begin
          deb_cnt[b] <= '0;
        end
      end
    end
  end

  // 5-bit arithmetic gives the 31<->0 wrap for free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      displaySelect <= '0;
    end else begin
      case (pulse)
        2'b01:   displaySelect <= displaySelect + 5'd1;
        2'b10:   displaySelect <= displaySelect - 5'd1;
        default: displaySelect <= displaySelect;
      endcase
    end
  end

  assign led_sel = displaySelect;

  logic [TW-1:0] tick_cnt;
  logic [2:0]    digit;
  logic [31:0]   snapshot;
  logic          tick;
  logic [3:0]    nibble;
  logic [31:0]   upper;
  logic [6:0]    seg_next;

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    nibble   = snapshot[{digit, 2'b00} +: 4];
    upper    = snapshot >> {digit, 2'b00};
    seg_next = 7'h7F;
    case (nibble)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      4'hF: seg_next = 7'b0001110;
      default: seg_next = 7'h7F;
    endcase
`ifdef DISPLAY_ZERO_BLANK_EN
    if ((digit != 3'd0) && (upper == 32'd0)) seg_next = 7'h7F;
`endif
  end

  // The snapshot reloads on the same tick that lights digit 7, so the next frame is consistent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      digit    <= '0;
      snapshot <= '0;
      seg      <= 7'h7F;
      an       <= 8'hFF;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        seg   <= seg_next;
        an    <= ~(8'b1 << digit);
        digit <= digit + 3'd1;
        if (digit == 3'd7) snapshot <= displayData;
      end
    end
  end

endmodule
